// File: rtl/bram_dp_sync.sv
// bram_dp_sync: single-clock true-dual-port RAM with byte enables, 1- or 2-cycle reads,
// a same-address collision flag and an optional post-reset clear (BRAM_CLEAR_ON_RESET_EN).
module bram_dp_sync #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 1024,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_a,
  input  logic                    we_a,
  input  logic [DATA_WIDTH/8-1:0] be_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   din_a,
  output logic [DATA_WIDTH-1:0]   dout_a,
  output logic                    rvalid_a,
  input  logic                    en_b,
  input  logic                    we_b,
  input  logic [DATA_WIDTH/8-1:0] be_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH-1:0]   din_b,
  output logic [DATA_WIDTH-1:0]   dout_b,
  output logic                    rvalid_b,
  output logic                    ready,
  output logic                    collision
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic acc_a, acc_b, inr_a, inr_b, wr_a, wr_b;
  logic [DATA_WIDTH-1:0] s1_dout_a_d, s1_dout_b_d;
  logic [DATA_WIDTH-1:0] s1_dout_a_q, s1_dout_b_q;
  logic                  s1_rv_a_q, s1_rv_b_q, collision_q;

  assign acc_a = en_a & ready;
  assign acc_b = en_b & ready;
  assign inr_a = {1'b0, addr_a} < DEPTH_W;
  assign inr_b = {1'b0, addr_b} < DEPTH_W;
  assign wr_a  = acc_a & we_a & inr_a;
  assign wr_b  = acc_b & we_b & inr_b;

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_w,
                                                  input logic [DATA_WIDTH-1:0] wdat,
                                                  input logic [NB-1:0]         be);
    merge = old_w;
    for (int i = 0; i < NB; i++)
      if (be[i]) merge[8*i +: 8] = wdat[8*i +: 8];
  endfunction

`ifdef BRAM_CLEAR_ON_RESET_EN
  // state | meaning
  // IDLE  | parked, not entered from reset; falls straight into CLEAR
  // CLEAR | writing 0 to word clr_ptr_q each cycle, ports blocked
  // DONE  | clear finished, ports accept requests
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic                  clr_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d   = CLEAR;
        clr_ptr_d = '0;
      end
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_ptr_q == LAST) state_d = DONE;
        else clr_ptr_d = clr_ptr_q + 1'b1;
      end
      DONE: ;
      default: state_d = CLEAR;
    endcase
  end

  assign ready = (state_q == DONE);
`else
  assign ready = 1'b1;
`endif

  // B is applied first so that A wins any byte both ports write.
  always_ff @(posedge clk) begin
`ifdef BRAM_CLEAR_ON_RESET_EN
    if (clr_we) mem[clr_ptr_q] <= '0;
`endif
    for (int i = 0; i < NB; i++) begin
      if (wr_b && be_b[i]) mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
      if (wr_a && be_a[i]) mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
    end
  end

  always_comb begin
    s1_dout_a_d = '0;
    if (inr_a) begin
      s1_dout_a_d = mem[addr_a];
      if (WRITE_MODE == 1 && we_a) s1_dout_a_d = merge(mem[addr_a], din_a, be_a);
    end
  end

  always_comb begin
    s1_dout_b_d = '0;
    if (inr_b) begin
      s1_dout_b_d = mem[addr_b];
      if (WRITE_MODE == 1 && we_b) s1_dout_b_d = merge(mem[addr_b], din_b, be_b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_dout_a_q <= '0;
      s1_dout_b_q <= '0;
      s1_rv_a_q   <= 1'b0;
      s1_rv_b_q   <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      s1_rv_a_q   <= acc_a;
      s1_rv_b_q   <= acc_b;
      if (acc_a) s1_dout_a_q <= s1_dout_a_d;
      if (acc_b) s1_dout_b_q <= s1_dout_b_d;
      collision_q <= acc_a & acc_b & (addr_a == addr_b) & (we_a | we_b);
    end
  end

  assign collision = collision_q;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s2_dout_a_q, s2_dout_b_q;
      logic                  s2_rv_a_q, s2_rv_b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_dout_a_q <= '0;
          s2_dout_b_q <= '0;
          s2_rv_a_q   <= 1'b0;
          s2_rv_b_q   <= 1'b0;
        end else begin
          s2_rv_a_q <= s1_rv_a_q;
          s2_rv_b_q <= s1_rv_b_q;
          if (s1_rv_a_q) s2_dout_a_q <= s1_dout_a_q;
          if (s1_rv_b_q) s2_dout_b_q <= s1_dout_b_q;
        end
      end

      assign dout_a   = s2_dout_a_q;
      assign dout_b   = s2_dout_b_q;
      assign rvalid_a = s2_rv_a_q;
      assign rvalid_b = s2_rv_b_q;
    end else begin : g_lat1
      assign dout_a   = s1_dout_a_q;
      assign dout_b   = s1_dout_b_q;
      assign rvalid_a = s1_rv_a_q;
      assign rvalid_b = s1_rv_b_q;
    end
  endgenerate

endmodule

// File: tb/tb_bram_dp_sync.sv
// Bench for bram_dp_sync: two instances (depth 16/latency 1/read-first and depth 12/latency 2/
// write-first) share one stimulus stream and are checked every cycle against a word-level model.
`timescale 1ns/1ps
module tb_bram_dp_sync;

  localparam int DEP [2] = '{16, 12};
  localparam int RL  [2] = '{1, 2};
  localparam int WM  [2] = '{0, 1};
`ifdef BRAM_CLEAR_ON_RESET_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
  logic [3:0]  be_a = '0, be_b = '0, addr_a = '0, addr_b = '0;
  logic [31:0] din_a = '0, din_b = '0;
  logic [31:0] dout_a [2], dout_b [2];
  logic        rvalid_a [2], rvalid_b [2], ready [2], collision [2];

  int cmp_cnt = 0;
  int mis_cnt = 0;

  always #5 clk = ~clk;

  bram_dp_sync #(.DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(4), .READ_LATENCY(1), .WRITE_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a[0]), .rvalid_a(rvalid_a[0]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b[0]), .rvalid_b(rvalid_b[0]),
    .ready(ready[0]), .collision(collision[0]));

  bram_dp_sync #(.DATA_WIDTH(32), .DEPTH(12), .ADDR_WIDTH(4), .READ_LATENCY(2), .WRITE_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(dout_a[1]), .rvalid_a(rvalid_a[1]),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b[1]), .rvalid_b(rvalid_b[1]),
    .ready(ready[1]), .collision(collision[1]));

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s[u%0d] t=%0t: got %h, expected %h", nm, i, $time, act, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [31:0] mm [2][16];
  bit          mk [2][16];     // word contents are known
  int          ecnt [2];       // clear cycles elapsed since reset release
  logic [31:0] sd [2][2];
  bit          sv [2][2], sk [2][2];
  logic [31:0] xd [2][2];
  bit          xv [2][2], xk [2][2];
  bit          xcol [2], xrdy [2];

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  task automatic model_edge(input int i);
    bit          rdy, ov, okn;
    bit          acc [2], w [2], inr [2], nk [2];
    logic [3:0]  ad [2], bb [2];
    logic [31:0] dn [2], nd [2], od;
    ad = '{addr_a, addr_b};
    bb = '{be_a, be_b};
    dn = '{din_a, din_b};
    w  = '{we_a, we_b};
    rdy = !CLR || ecnt[i] >= DEP[i];
    if (!rdy) begin
      mm[i][ecnt[i]] = '0;
      mk[i][ecnt[i]] = 1'b1;
      ecnt[i]++;
    end
    acc[0] = en_a && rdy;
    acc[1] = en_b && rdy;
    for (int p = 0; p < 2; p++) begin
      inr[p] = int'(ad[p]) < DEP[i];
      nd[p] = '0;
      nk[p] = 1'b1;
      if (acc[p] && inr[p]) begin
        nd[p] = mm[i][ad[p]];
        nk[p] = mk[i][ad[p]];
        if (WM[i] == 1 && w[p]) begin
          nd[p] = bmerge(mm[i][ad[p]], dn[p], bb[p]);
          if (bb[p] == 4'hF) nk[p] = 1'b1;
        end
      end
    end
    xcol[i] = acc[0] && acc[1] && ad[0] == ad[1] && (w[0] || w[1]);
    // port B first, then A, so A owns bytes both ports enable
    for (int p = 1; p >= 0; p--)
      if (acc[p] && w[p] && inr[p]) begin
        mm[i][ad[p]] = bmerge(mm[i][ad[p]], dn[p], bb[p]);
        if (bb[p] == 4'hF) mk[i][ad[p]] = 1'b1;
      end
    for (int p = 0; p < 2; p++) begin
      if (RL[i] == 1) begin
        ov = acc[p]; od = nd[p]; okn = nk[p];
      end else begin
        ov = sv[i][p]; od = sd[i][p]; okn = sk[i][p];
        sv[i][p] = acc[p]; sd[i][p] = nd[p]; sk[i][p] = nk[p];
      end
      xv[i][p] = ov;
      if (ov) begin
        xd[i][p] = od;
        xk[i][p] = okn;
      end
    end
    xrdy[i] = !CLR || ecnt[i] >= DEP[i];
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        ecnt[i] = 0;
        xcol[i] = 1'b0;
        xrdy[i] = !CLR;
        for (int p = 0; p < 2; p++) begin
          sv[i][p] = 1'b0; sd[i][p] = '0; sk[i][p] = 1'b1;
          xv[i][p] = 1'b0; xd[i][p] = '0; xk[i][p] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) model_edge(i);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rvalid_a", i, 32'(rvalid_a[i]), 32'(xv[i][0]));
      chk("rvalid_b", i, 32'(rvalid_b[i]), 32'(xv[i][1]));
      chk("ready", i, 32'(ready[i]), 32'(xrdy[i]));
      chk("collision", i, 32'(collision[i]), 32'(xcol[i]));
      if (xk[i][0]) chk("dout_a", i, dout_a[i], xd[i][0]);
      if (xk[i][1]) chk("dout_b", i, dout_b[i], xd[i][1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit ea, input bit wa, input logic [3:0] ba, input logic [3:0] aa,
                       input logic [31:0] da, input bit eb, input bit wb, input logic [3:0] bbv,
                       input logic [3:0] ab, input logic [31:0] db);
    en_a = ea; we_a = wa; be_a = ba; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; be_b = bbv; addr_b = ab; din_b = db;
  endtask

  task automatic idle();
    drive(0, 0, 4'h0, 4'h0, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    step(); step();
    for (int i = 0; i < 2; i++) begin
      chk("reset dout_a", i, dout_a[i], 32'h0);
      chk("reset rvalid_a", i, 32'(rvalid_a[i]), 32'h0);
      chk("reset collision", i, 32'(collision[i]), 32'h0);
      chk("reset ready", i, 32'(ready[i]), 32'(!CLR));
    end
    rst_n = 1'b1;

`ifdef BRAM_CLEAR_ON_RESET_EN
    drive(1, 0, 4'h0, 4'h0, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
    for (int k = 0; k < 15; k++) step();
    chk("clear ready@15", 0, 32'(ready[0]), 32'h0);
    step();
    chk("clear ready@16", 0, 32'(ready[0]), 32'h1);
    chk("clear rvalid@16", 0, 32'(rvalid_a[0]), 32'h0);
    step();
    chk("clear rvalid@17", 0, 32'(rvalid_a[0]), 32'h1);
    for (int a = 0; a < 16; a++) begin
      drive(1, 0, 4'h0, 4'(a), 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
      step();
      chk("clear read", 0, dout_a[0], 32'h0);
    end
    idle(); step(); step();
`endif

    for (int a = 0; a < 16; a++) begin
      drive(1, 1, 4'hF, 4'(a), 32'h0, 0, 0, 4'h0, 4'h0, 32'h0);
      step();
    end
    idle(); step(); step();

    // byte enables
    drive(1, 1, 4'hF, 4'd5, 32'hAABBCCDD, 0, 0, 4'h0, 4'h0, 32'h0); step();
    drive(1, 1, 4'h5, 4'd5, 32'h11223344, 0, 0, 4'h0, 4'h0, 32'h0); step();
    drive(1, 0, 4'h0, 4'd5, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0); step();
    chk("be dout L1", 0, dout_a[0], 32'hAA22CC44);
    chk("be rvalid L1", 0, 32'(rvalid_a[0]), 32'h1);
    idle(); step();
    chk("be rvalid L1 drop", 0, 32'(rvalid_a[0]), 32'h0);
    chk("be rvalid L2", 1, 32'(rvalid_a[1]), 32'h1);
    chk("be dout L2", 1, dout_a[1], 32'hAA22CC44);
    step();
    chk("be rvalid L2 drop", 1, 32'(rvalid_a[1]), 32'h0);

    // read-during-write, plus cross-port read of the same word
    drive(1, 1, 4'hF, 4'd3, 32'hDEADBEEF, 1, 0, 4'h0, 4'd3, 32'h0); step();
    chk("rdw read-first a", 0, dout_a[0], 32'h0);
    chk("rdw cross b", 0, dout_b[0], 32'h0);
    chk("rdw collision", 0, 32'(collision[0]), 32'h1);
    idle(); step();
    chk("rdw write-first a", 1, dout_a[1], 32'hDEADBEEF);
    chk("rdw cross b", 1, dout_b[1], 32'h0);
    chk("rdw collision drop", 0, 32'(collision[0]), 32'h0);

    // both ports write the same word
    drive(1, 1, 4'h1, 4'd7, 32'h000000FF, 1, 1, 4'hF, 4'd7, 32'hFFFFFF00); step();
    chk("col pulse", 0, 32'(collision[0]), 32'h1);
    drive(1, 0, 4'h0, 4'd7, 32'h0, 1, 0, 4'h0, 4'd2, 32'h0); step();
    chk("col merged", 0, dout_a[0], 32'hFFFFFFFF);
    chk("col diff addr", 0, 32'(collision[0]), 32'h0);
    idle(); step();
    chk("col merged", 1, dout_a[1], 32'hFFFFFFFF);

    // mixed directed traffic, including addresses beyond u1's depth
    for (int k = 0; k < 32; k++) begin
      drive(1, (k % 3) == 0, 4'(k * 7), 4'(k * 5), 32'h9E3779B9 * k + 32'h0F0F0001,
            (k % 5) != 4, (k % 4) == 1, 4'(k * 3 + 2),
            ((k % 8) == 2) ? 4'(k * 5) : 4'(k * 3 + 1), 32'hC2B2AE35 ^ (32'h01010101 * k));
      step();
    end
    idle(); step(); step();

    // out of range on u1
    drive(1, 1, 4'hF, 4'd13, 32'h00000005, 0, 0, 4'h0, 4'h0, 32'h0); step();
    drive(1, 0, 4'h0, 4'd13, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0); step();
    chk("in-range 13", 0, dout_a[0], 32'h00000005);
    idle(); step();
    chk("oor rvalid", 1, 32'(rvalid_a[1]), 32'h1);
    chk("oor dout", 1, dout_a[1], 32'h0);
    for (int a = 0; a < 12; a++) begin
      drive(1, 0, 4'h0, 4'(a), 32'h0, 1, 0, 4'h0, 4'(11 - a), 32'h0);
      step();
    end
    idle(); step(); step();

    // reset in the middle of back-to-back reads
    drive(1, 0, 4'h0, 4'd5, 32'h0, 1, 0, 4'h0, 4'd7, 32'h0);
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("mid-rst rvalid_a", i, 32'(rvalid_a[i]), 32'h0);
      chk("mid-rst rvalid_b", i, 32'(rvalid_b[i]), 32'h0);
      chk("mid-rst dout_a", i, dout_a[i], 32'h0);
      chk("mid-rst dout_b", i, dout_b[i], 32'h0);
      chk("mid-rst collision", i, 32'(collision[i]), 32'h0);
      chk("mid-rst ready", i, 32'(ready[i]), 32'(!CLR));
    end
    idle(); step();
    rst_n = 1'b1;
`ifdef BRAM_CLEAR_ON_RESET_EN
    for (int k = 0; k < 17; k++) step();
`endif
    drive(1, 0, 4'h0, 4'd5, 32'h0, 1, 0, 4'h0, 4'd7, 32'h0); step();
`ifdef BRAM_CLEAR_ON_RESET_EN
    chk("post-clear read", 0, dout_a[0], 32'h0);
`endif
    idle(); step(); step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
